// File: rtl/credit_unit.sv
// Coin credit accumulator and change dispenser for the vending controller.
// Define CREDIT_CHANGE_500_EN to pay change in 500 coins while credit >= 5.
module credit_unit #(
    parameter int unsigned MAX_CREDIT = 20,
    parameter int unsigned PRICE_E    = 3,
    parameter int unsigned PRICE_L    = 4,
    parameter int unsigned PRICE_X    = 5,
    parameter int unsigned PRICE_M    = 7,
    parameter int unsigned PULSE_CYC  = 4,
    parameter int unsigned GAP_CYC    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en_cien,
    input  logic       en_quin,
    input  logic [7:0] valor_producto,
    input  logic       vuelto,
    output logic       m0,
    output logic       m1,
    output logic       m2,
    output logic       m3,
    output logic       m4,
    output logic [7:0] credit,
    output logic       out_cien,
    output logic       out_quin,
    output logic       busy
);

    typedef enum logic [1:0] {IDLE, EJ_REJ, PAY_HI, PAY_LO} state_t;

    localparam logic [8:0]  MAX9     = 9'(MAX_CREDIT);
    localparam logic [7:0]  PE8      = 8'(PRICE_E);
    localparam logic [7:0]  PL8      = 8'(PRICE_L);
    localparam logic [7:0]  PX8      = 8'(PRICE_X);
    localparam logic [7:0]  PM8      = 8'(PRICE_M);
    localparam logic [15:0] HI_CYC   = 16'(PULSE_CYC);
    localparam logic [15:0] HI_LAST  = 16'(PULSE_CYC - 1);
    localparam logic [15:0] LO_LAST  = 16'(GAP_CYC - 1);
    localparam logic [15:0] REJ_LAST = 16'(PULSE_CYC + GAP_CYC - 1);

    state_t      state, state_nx;
    logic [15:0] cnt, cnt_nx;
    logic [7:0]  credit_q, credit_nx;
    logic        rej_pend, rej_pend_nx;
    logic        rej_quin, rej_quin_nx;
    logic        coin5, coin5_nx;
    logic [3:0]  m_q;
    logic        take500;
    logic        strobe, coin_acc, coin_rej;
    logic [7:0]  coin_add, pay_dec, pay, after_pay, vend;

`ifdef CREDIT_CHANGE_500_EN
    assign take500 = (credit_q >= 8'd5);
`else
    assign take500 = 1'b0;
`endif

    assign busy   = (state != IDLE);
    assign strobe = en_cien | en_quin;

    always_comb begin
        m0 = 1'b0;
        if (en_cien)
            m0 = busy | (({1'b0, credit_q} + 9'd1) > MAX9);
        else if (en_quin)
            m0 = busy | (({1'b0, credit_q} + 9'd5) > MAX9);
    end

    assign coin_acc = strobe & ~m0;
    assign coin_rej = strobe & m0;

    always_comb begin
        state_nx    = state;
        cnt_nx      = cnt;
        coin5_nx    = coin5;
        rej_pend_nx = rej_pend;
        rej_quin_nx = rej_quin;
        pay_dec     = '0;
        case (state)
            IDLE: begin
                if (vuelto) begin
                    if (rej_pend) begin
                        // coin5 doubles as the latched eject type so a new rejection can't retarget it
                        state_nx    = EJ_REJ;
                        cnt_nx      = '0;
                        coin5_nx    = rej_quin;
                        rej_pend_nx = 1'b0;
                    end else if (credit_q != 8'd0) begin
                        state_nx = PAY_HI;
                        cnt_nx   = '0;
                        coin5_nx = take500;
                    end
                end
            end
            EJ_REJ: begin
                if (cnt == REJ_LAST) state_nx = IDLE;
                else                 cnt_nx   = cnt + 16'd1;
            end
            PAY_HI: begin
                if (cnt == HI_LAST) begin
                    state_nx = PAY_LO;
                    cnt_nx   = '0;
                    pay_dec  = coin5 ? 8'd5 : 8'd1;
                end else begin
                    cnt_nx = cnt + 16'd1;
                end
            end
            PAY_LO: begin
                if (cnt == LO_LAST) begin
                    cnt_nx = '0;
                    if (credit_q != 8'd0) begin
                        state_nx = PAY_HI;
                        coin5_nx = take500;
                    end else begin
                        state_nx = IDLE;
                    end
                end else begin
                    cnt_nx = cnt + 16'd1;
                end
            end
            default: state_nx = IDLE;
        endcase
        if (coin_rej) begin
            rej_pend_nx = 1'b1;
            rej_quin_nx = ~en_cien;
        end
    end

    // Payout and vend are both clamped so credit can never wrap below zero.
    always_comb begin
        coin_add  = '0;
        if (coin_acc) coin_add = en_cien ? 8'd1 : 8'd5;
        pay       = (pay_dec > credit_q) ? credit_q : pay_dec;
        after_pay = credit_q - pay;
        vend      = '0;
        if (valor_producto != 8'd0 && valor_producto <= after_pay)
            vend = valor_producto;
        credit_nx = after_pay - vend + coin_add;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            credit_q <= '0;
            rej_pend <= 1'b0;
            rej_quin <= 1'b0;
            coin5    <= 1'b0;
            m_q      <= '0;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            credit_q <= credit_nx;
            rej_pend <= rej_pend_nx;
            rej_quin <= rej_quin_nx;
            coin5    <= coin5_nx;
            m_q      <= {credit_nx >= PM8, credit_nx >= PX8,
                         credit_nx >= PL8, credit_nx >= PE8};
        end
    end

    assign {m4, m3, m2, m1} = m_q;
    assign credit = credit_q;

    always_comb begin
        out_cien = 1'b0;
        out_quin = 1'b0;
        if (state == PAY_HI || (state == EJ_REJ && cnt < HI_CYC)) begin
            out_cien = ~coin5;
            out_quin = coin5;
        end
    end

endmodule

// File: tb/tb_credit_unit.sv
// Randomized bench for credit_unit against a per-cycle expected-waveform model.
// Build with or without CREDIT_CHANGE_500_EN to match the RTL configuration.
module tb_credit_unit;

    localparam int MAX_CREDIT = 20;
    localparam int PRICE_E    = 3;
    localparam int PRICE_L    = 4;
    localparam int PRICE_X    = 5;
    localparam int PRICE_M    = 7;
    localparam int PULSE_CYC  = 4;
    localparam int GAP_CYC    = 4;
`ifdef CREDIT_CHANGE_500_EN
    localparam bit EN500 = 1'b1;
`else
    localparam bit EN500 = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en_cien = 1'b0, en_quin = 1'b0, vuelto = 1'b0;
    logic [7:0] valor_producto = '0;
    logic       m0, m1, m2, m3, m4, out_cien, out_quin, busy;
    logic [7:0] credit;

    credit_unit #(
        .MAX_CREDIT(MAX_CREDIT), .PRICE_E(PRICE_E), .PRICE_L(PRICE_L),
        .PRICE_X(PRICE_X), .PRICE_M(PRICE_M),
        .PULSE_CYC(PULSE_CYC), .GAP_CYC(GAP_CYC)
    ) dut (
        .clk(clk), .rst(rst), .en_cien(en_cien), .en_quin(en_quin),
        .valor_producto(valor_producto), .vuelto(vuelto),
        .m0(m0), .m1(m1), .m2(m2), .m3(m3), .m4(m4), .credit(credit),
        .out_cien(out_cien), .out_quin(out_quin), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit busy;
        bit cien;
        bit quin;
        int credit;
    } wave_t;

    wave_t wave[$];
    int    cr   = 0;
    bit    rejp = 1'b0;
    bit    rejq = 1'b0;
    int    n_checks = 0;
    int    n_fail   = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic push_coin(input bit c, input bit q, input int hi_cr, input int lo_cr);
        for (int i = 0; i < PULSE_CYC; i++) wave.push_back('{busy: 1'b1, cien: c, quin: q, credit: hi_cr});
        for (int i = 0; i < GAP_CYC; i++)   wave.push_back('{busy: 1'b1, cien: 1'b0, quin: 1'b0, credit: lo_cr});
    endtask

    // One clock cycle: check registered outputs, drive inputs, check m0, advance model.
    task automatic step(input bit c_in, input bit q_in, input int v_in, input bit vu_in);
        wave_t w;
        bit    bsy, m0e, rej;
        int    cur, val, nc, cc, coin;
        @(negedge clk);
        bsy = (wave.size() > 0);
        if (bsy) w = wave[0];
        else     w = '{busy: 1'b0, cien: 1'b0, quin: 1'b0, credit: cr};
        cur = w.credit;
        check("credit", int'(credit), cur);
        check("busy", int'(busy), int'(w.busy));
        check("out_cien", int'(out_cien), int'(w.cien));
        check("out_quin", int'(out_quin), int'(w.quin));
        check("m4m3m2m1", int'({m4, m3, m2, m1}),
              int'({cur >= PRICE_M, cur >= PRICE_X, cur >= PRICE_L, cur >= PRICE_E}));
        en_cien = c_in;
        en_quin = q_in;
        valor_producto = 8'(v_in);
        vuelto = vu_in;
        #1;
        val = c_in ? 1 : 5;
        m0e = (c_in || q_in) && (bsy || (cur + val > MAX_CREDIT));
        check("m0", int'(m0), int'(m0e));
        rej = (c_in || q_in) && m0e;
        if (bsy) begin
            cr = w.credit;
            void'(wave.pop_front());
        end else begin
            nc = cr;
            if ((c_in || q_in) && !m0e) nc += val;
            if (v_in != 0 && v_in <= cr) nc -= v_in;
            if (vu_in) begin
                if (rejp) begin
                    rejp = 1'b0;
                    push_coin(!rejq, rejq, cr, cr);
                end else if (cr > 0) begin
                    cc = cr;
                    while (cc > 0) begin
                        coin = (EN500 && cc >= 5) ? 5 : 1;
                        push_coin(coin == 1, coin == 5, cc, cc - coin);
                        cc -= coin;
                    end
                end
            end
            cr = nc;
        end
        if (rej) begin
            rejp = 1'b1;
            rejq = !c_in;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_credit"}, int'(credit), 0);
        check({tag, "_outs"}, int'({busy, out_cien, out_quin, m4, m3, m2, m1}), 0);
    endtask

    task automatic mid_reset();
        @(negedge clk);
        en_cien = 1'b0; en_quin = 1'b0; valor_producto = '0; vuelto = 1'b0;
        #2 rst = 1'b1;
        #1;
        check_all_zero("async_rst");
        cr = 0; rejp = 1'b0; wave.delete();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;

        // 500 + 100 + 100 -> 7, all thresholds met
        step(0, 1, 0, 0); step(1, 0, 0, 0); step(1, 1, 0, 0); idle(1);
        // vend 4 from 7 -> 3
        step(0, 0, 4, 0); idle(1);
        // climb to 18, reject a 500, return it, credit kept
        step(0, 1, 0, 0); step(0, 1, 0, 0); step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        step(0, 0, 0, 1); idle(PULSE_CYC + GAP_CYC + 2);
        // vend 10 -> 8, then full payout
        step(0, 0, 10, 0);
        step(0, 0, 0, 1); idle(8 * (PULSE_CYC + GAP_CYC) + 2);
        // credit 2, price 5 ignored
        step(1, 0, 0, 0); step(1, 0, 0, 0); step(0, 0, 5, 0); idle(2);
        // saturation at MAX_CREDIT with 100 coins
        for (int i = 0; i < 20; i++) step(1, 0, 0, 0);
        step(0, 0, 0, 1); idle(2);
        mid_reset();
        idle(1);

        // credit 6 payout, coin while busy, then asynchronous reset mid-payout
        step(0, 1, 0, 0); step(1, 0, 0, 0);
        step(0, 0, 0, 1); idle(2); step(1, 0, 0, 0); idle(1);
        mid_reset();
        idle(2);

        for (int i = 0; i < 4000; i++) begin
            int r;
            r = $urandom_range(0, 99);
            if (wave.size() > 0)
                step($urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0, 0,
                     $urandom_range(0, 9) == 0);
            else if (r < 6)
                step(0, 0, 0, 1);
            else if (r < 18)
                step(0, 0, $urandom_range(1, 12), 0);
            else if (r < 26)
                step($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(1, 12), 0);
            else if (r < 70)
                step($urandom_range(0, 2) == 0, $urandom_range(0, 1), 0, 0);
            else
                step(0, 0, 0, 0);
            if (i == 2500) mid_reset();
        end
        idle(1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
